// File: rtl/mash_pkg.sv
// mash_pkg: shared types and constants for the MASH noise-cancellation network.
//   order_t    - 3-bit unsigned modulator order M
//   state_t    - network sequencing state (FLUSH while history fills, RUN after)
//   out_width  - signed output width for a given cascade length
//   P_STAGES_MIN / P_STAGES_MAX - supported cascade lengths
package mash_pkg;

  localparam int P_STAGES_MIN = 1;
  localparam int P_STAGES_MAX = 4;

  typedef logic [2:0] order_t;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // An M-stage network spans -(2^(M-1)-1) .. 2^(M-1), which needs M+1 signed bits.
  function automatic int out_width(input int stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/mash_nc_network_p_if.sv
// mash_nc_network_p_if: sample/config bus between the accumulator cascade
// (master) and the noise-cancellation network (slave).
//   i_valid/i_carry       - carry sample, one bit per stage (bit 0 = stage 1)
//   i_cfg_we/i_order      - single-cycle order load
//   i_clr                 - synchronous clear of filter state
//   o_valid/o_data        - registered signed NC output sample
//   o_order/o_cfg_err     - active order and sticky illegal-order flag
//   o_state               - sequencing state, exported for observation
//
// Handshake: valid-only, there is no back-pressure. A sample is accepted in
// any cycle where i_valid=1 and neither a legal i_cfg_we nor i_clr is high;
// o_valid=1 marks exactly one output sample, in the cycle after its accepted
// input, and the consumer must take it in that cycle.
interface mash_nc_network_p_if #(
  parameter int P_STAGES = 3
) ();
  import mash_pkg::*;

  localparam int P_OUT_W = out_width(P_STAGES);

  logic                       i_valid;
  logic [P_STAGES-1:0]        i_carry;
  logic                       i_cfg_we;
  order_t                     i_order;
  logic                       i_clr;
  logic                       o_valid;
  logic signed [P_OUT_W-1:0]  o_data;
  order_t                     o_order;
  logic                       o_cfg_err;
  state_t                     o_state;

  modport master (
    output i_valid, i_carry, i_cfg_we, i_order, i_clr,
    input  o_valid, o_data, o_order, o_cfg_err, o_state
  );

  modport slave (
    input  i_valid, i_carry, i_cfg_we, i_order, i_clr,
    output o_valid, o_data, o_order, o_cfg_err, o_state
  );

endinterface

// File: rtl/mash_nc_stage.sv
// mash_nc_stage: one term of the NC network, t_k = c_k*z^-(M-k) + (1-z^-1)*t_(k+1).
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_en           - accepted sample: advance delay line and differentiator
//   i_clr          - synchronous zero of delay line and differentiator
//   i_carry        - carry bit of stage K
//   i_order        - active order M, selects tap M-K
//   i_t_next       - t_(K+1), forced to zero by the parent when K >= M
//   o_t            - t_K, combinational
module mash_nc_stage
  import mash_pkg::*;
#(
  parameter int P_STAGES = 3,
  parameter int K        = 1,
  parameter int W        = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic                i_carry,
  input  order_t              i_order,
  input  logic signed [W-1:0] i_t_next,
  output logic signed [W-1:0] o_t
);

  // A one-stage cascade never uses a delayed tap; keep one flop so the
  // vector stays legal.
  localparam int DEPTH = (P_STAGES > 1) ? P_STAGES - 1 : 1;

  logic [DEPTH-1:0]    dly_q;
  logic [DEPTH:0]      taps;
  logic                tap;
  logic signed [W-1:0] diff_q;

  // taps[j] is the carry delayed by j accepted samples.
  assign taps = {dly_q, i_carry};

  always_comb begin
    tap = 1'b0;
    for (int j = 0; j <= DEPTH; j++) begin
      if (i_order >= order_t'(K) && (i_order - order_t'(K)) == order_t'(j)) begin
        tap = taps[j];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dly_q  <= '0;
      diff_q <= '0;
    end else if (i_clr) begin
      dly_q  <= '0;
      diff_q <= '0;
    end else if (i_en) begin
      dly_q  <= taps[DEPTH-1:0];
      diff_q <= i_t_next;
    end
  end

  assign o_t = $signed({{(W-1){1'b0}}, tap}) + i_t_next - diff_q;

endmodule

// File: rtl/mash_nc_network_p.sv
// mash_nc_network_p: run-time order-selectable MASH noise-cancellation network.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   bus            - mash_nc_network_p_if.slave (carry samples in, NC word out,
//                    order configuration, clear, status)
// Output for order M is Y = t_1 of the recursion t_k = c_k z^-(M-k) +
// (1-z^-1) t_(k+1), t_M = c_M, advanced only on accepted samples. After a
// reset, clear or order load the first M-1 accepted samples are hidden
// while the delay lines fill.
module mash_nc_network_p
  import mash_pkg::*;
#(
  parameter int P_STAGES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  mash_nc_network_p_if.slave    bus
);

  localparam int P_OUT_W = out_width(P_STAGES);

  state_t                     state_q, state_nx;
  logic [1:0]                 cnt_q, cnt_nx;
  order_t                     order_q, order_nx;
  logic                       err_q;
  logic                       valid_q;
  logic signed [P_OUT_W-1:0]  data_q;

  logic cfg_legal, cfg_load, restart, accept, emit;

  logic signed [P_OUT_W-1:0]  t_arr  [P_STAGES+1];
  logic signed [P_OUT_W-1:0]  t_next [P_STAGES];

  assign cfg_legal = (bus.i_order >= order_t'(P_STAGES_MIN)) &&
                     (bus.i_order <= order_t'(P_STAGES));
  assign cfg_load  = bus.i_cfg_we && cfg_legal;
  // Illegal loads leave everything alone, including the sample in flight.
  assign restart   = cfg_load || bus.i_clr;
  assign accept    = bus.i_valid && !restart;
  assign order_nx  = cfg_load ? bus.i_order : order_q;
  // Order 1 has no history to fill, so its samples are never hidden.
  assign emit      = accept && (state_q == ST_RUN || order_q == 3'd1);

  assign t_arr[P_STAGES] = '0;

  for (genvar g = 0; g < P_STAGES; g++) begin : g_stage
    // Stage M and above start from t_(k+1) = 0; only t_1..t_M are used.
    assign t_next[g] = (order_q > order_t'(g + 1)) ? t_arr[g + 1] : '0;

    mash_nc_stage #(
      .P_STAGES (P_STAGES),
      .K        (g + 1),
      .W        (P_OUT_W)
    ) u_stage (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (accept),
      .i_clr    (restart),
      .i_carry  (bus.i_carry[g]),
      .i_order  (order_q),
      .i_t_next (t_next[g]),
      .o_t      (t_arr[g])
    );
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    if (restart) begin
      state_nx = (order_nx == 3'd1) ? ST_RUN : ST_FLUSH;
      cnt_nx   = '0;
    end else if (state_q == ST_FLUSH) begin
      if (order_q == 3'd1) begin
        state_nx = ST_RUN;
      end else if (accept) begin
        // The (M-1)th hidden sample completes the flush.
        if ({1'b0, cnt_q} == order_q - 3'd2) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FLUSH;
      cnt_q   <= '0;
      order_q <= order_t'(P_STAGES);
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      order_q <= order_nx;
      err_q   <= err_q | (bus.i_cfg_we & ~cfg_legal);
      valid_q <= emit;
      if (restart) begin
        data_q <= '0;
      end else if (emit) begin
        data_q <= t_arr[0];
      end
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_data    = data_q;
  assign bus.o_order   = order_q;
  assign bus.o_cfg_err = err_q;
  assign bus.o_state   = state_q;

endmodule

// File: tb/tb_mash_nc_network_p.sv
// tb_mash_nc_network_p: directed vector tables for a 3-stage and a 4-stage
// network, plus model-checked sequences for clear, random gated stream,
// order switching, illegal loads and asynchronous reset on the 3-stage one.
module tb_mash_nc_network_p;
  import mash_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mash_nc_network_p_if #(.P_STAGES(3)) bus3 ();
  mash_nc_network_p_if #(.P_STAGES(4)) bus4 ();

  mash_nc_network_p #(.P_STAGES(3)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3.slave));
  mash_nc_network_p #(.P_STAGES(4)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4.slave));

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit         v;
    logic [3:0] c;
    bit         ev;
    int         ed;
  } vec_t;

  vec_t tbl3[14];
  vec_t tbl4[17];

  // ---------------- golden model (3-stage DUT) ----------------
  // Y = sum_k c_k z^-(M-k) (1-z^-1)^(k-1), over accepted samples only.
  int         m_ord, m_hide, m_data;
  bit         m_valid, m_err;
  logic [2:0] m_hist[4];

  function automatic int fact(input int n);
    int f = 1;
    for (int i = 2; i <= n; i++) f *= i;
    return f;
  endfunction

  function automatic int coef(input int n, input int j);
    int b = fact(n) / (fact(j) * fact(n - j));
    return (j % 2 == 1) ? -b : b;
  endfunction

  function automatic int model_y();
    int y = 0;
    for (int k = 1; k <= m_ord; k++)
      for (int j = 0; j < k; j++)
        y += coef(k - 1, j) * int'(m_hist[(m_ord - k) + j][k - 1]);
    return y;
  endfunction

  task automatic model_reset();
    m_ord = 3; m_hide = 2; m_data = 0; m_valid = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
  endtask

  task automatic model_restart();
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
    m_hide = m_ord - 1; m_valid = 0; m_data = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle3();
    bus3.i_valid = 0; bus3.i_carry = '0; bus3.i_cfg_we = 0; bus3.i_order = '0; bus3.i_clr = 0;
  endtask

  task automatic idle4();
    bus4.i_valid = 0; bus4.i_carry = '0; bus4.i_cfg_we = 0; bus4.i_order = '0; bus4.i_clr = 0;
  endtask

  // One clock on the 3-stage DUT with the model advanced in step.
  task automatic run3(input bit v, input logic [2:0] c, input bit we,
                      input logic [2:0] ord, input bit clr, input string tag);
    bit legal;
    bus3.i_valid = v; bus3.i_carry = c; bus3.i_cfg_we = we; bus3.i_order = ord; bus3.i_clr = clr;
    legal = we && ord >= 3'd1 && ord <= 3'd3;
    if (legal) begin
      m_ord = int'(ord);
      model_restart();
    end else if (clr) begin
      model_restart();
    end else if (v) begin
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i - 1];
      m_hist[0] = c;
      if (m_hide > 0) begin
        m_hide--;
        m_valid = 0;
      end else begin
        m_valid = 1;
        m_data  = model_y();
      end
    end else begin
      m_valid = 0;
    end
    if (we && !legal) m_err = 1;
    @(posedge clk); #1;
    idle3();
    chk({tag, "_valid"}, int'(bus3.o_valid), int'(m_valid));
    chk({tag, "_data"},  int'(bus3.o_data),  m_data);
    chk({tag, "_order"}, int'(bus3.o_order), m_ord);
    chk({tag, "_err"},   int'(bus3.o_cfg_err), int'(m_err));
  endtask

  // ---------------- test ----------------
  initial begin
    // c3 impulse (with an idle gap), c1 impulse, c2 impulse; M=3 after reset.
    tbl3 = '{
      '{1, 4'b0000, 0, 0}, '{1, 4'b0000, 0, 0},
      '{1, 4'b0100, 1, 1}, '{0, 4'b0000, 0, 1}, '{1, 4'b0000, 1, -2},
      '{1, 4'b0000, 1, 1}, '{1, 4'b0000, 1, 0},
      '{1, 4'b0001, 1, 0}, '{1, 4'b0000, 1, 0}, '{1, 4'b0000, 1, 1},
      '{1, 4'b0010, 1, 0}, '{1, 4'b0000, 1, 1}, '{1, 4'b0000, 1, -1},
      '{1, 4'b0000, 1, 0}
    };
    // M=4: three flush samples, extremes +8 / -7, then all-ones settling to +1.
    tbl4 = '{
      '{1, 4'b0000, 0, 0}, '{1, 4'b0000, 0, 0}, '{1, 4'b0000, 0, 0},
      '{1, 4'b0101, 1, 0}, '{1, 4'b1010, 1, 2}, '{1, 4'b0100, 1, -5},
      '{1, 4'b1000, 1, 8}, '{1, 4'b1010, 1, -6}, '{1, 4'b0100, 1, 1},
      '{1, 4'b1000, 1, 5}, '{1, 4'b0000, 1, -7},
      '{1, 4'b1111, 1, 5}, '{1, 4'b1111, 1, -2}, '{1, 4'b1111, 1, 1},
      '{1, 4'b1111, 1, 1}, '{1, 4'b1111, 1, 1}, '{1, 4'b1111, 1, 1}
    };

    idle3(); idle4();
    model_reset();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst3_valid", int'(bus3.o_valid), 0);
    chk("rst3_data",  int'(bus3.o_data), 0);
    chk("rst3_order", int'(bus3.o_order), 3);
    chk("rst3_err",   int'(bus3.o_cfg_err), 0);
    chk("rst3_state", int'(bus3.o_state), int'(ST_FLUSH));
    chk("rst4_order", int'(bus4.o_order), 4);
    chk("rst4_data",  int'(bus4.o_data), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      bus3.i_valid = tbl3[i].v; bus3.i_carry = tbl3[i].c[2:0];
      @(posedge clk); #1;
      chk($sformatf("tbl3[%0d]_valid", i), int'(bus3.o_valid), int'(tbl3[i].ev));
      chk($sformatf("tbl3[%0d]_data", i),  int'(bus3.o_data),  tbl3[i].ed);
    end
    idle3();

    for (int i = 0; i < 17; i++) begin
      bus4.i_valid = tbl4[i].v; bus4.i_carry = tbl4[i].c;
      @(posedge clk); #1;
      chk($sformatf("tbl4[%0d]_valid", i), int'(bus4.o_valid), int'(tbl4[i].ev));
      chk($sformatf("tbl4[%0d]_data", i),  int'(bus4.o_data),  tbl4[i].ed);
    end
    idle4();

    // Clear in RUN (sample in the same cycle is dropped), then 2 hidden samples.
    run3(1, 3'b111, 0, 3'd0, 1, "clr");
    for (int i = 0; i < 4; i++) run3(1, 3'($urandom_range(0, 7)), 0, 3'd0, 0, "post_clr");

    // Random carries with i_valid toggling.
    for (int i = 0; i < 60; i++)
      run3(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0, 3'd0, 0, "rand");

    // Switch to M=1 mid-stream: cfg-cycle sample dropped, no flush gap.
    run3(1, 3'b111, 1, 3'd1, 0, "cfg1");
    for (int i = 0; i < 4; i++) run3(1, 3'($urandom_range(0, 7)), 0, 3'd0, 0, "m1");

    // Switch to M=2 together with a clear: one hidden sample.
    run3(1, 3'b101, 1, 3'd2, 1, "cfg2");
    for (int i = 0; i < 5; i++) run3(1, 3'($urandom_range(0, 7)), 0, 3'd0, 0, "m2");

    // Illegal loads: sticky error, order and stream unaffected.
    run3(0, 3'b000, 1, 3'd0, 0, "bad0");
    for (int i = 0; i < 2; i++) run3(1, 3'($urandom_range(0, 7)), 0, 3'd0, 0, "after_bad0");
    run3(0, 3'b000, 1, 3'd5, 0, "bad5");
    for (int i = 0; i < 3; i++) run3(1, 3'($urandom_range(0, 7)), 0, 3'd0, 0, "after_bad5");

    // Asynchronous reset mid-RUN, checked before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(bus3.o_valid), 0);
    chk("arst_data",  int'(bus3.o_data), 0);
    chk("arst_order", int'(bus3.o_order), 3);
    chk("arst_err",   int'(bus3.o_cfg_err), 0);
    chk("arst4_order", int'(bus4.o_order), 4);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) run3(1, 3'($urandom_range(0, 7)), 0, 3'd0, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mash_nc_network_p.md
# mash_nc_network_p

Parametrised noise-cancellation network for the MASH delta-sigma modulator. It combines the 1-bit carry outputs of up to P_STAGES cascaded first-order accumulators into one signed multi-level divider-control word. The active modulator order is selectable at run time, and sample processing is gated by a valid strobe. Output is registered. The block sits between the accumulator cascade and the divider-control interface, and generalises the fixed third-order network to orders 1..P_STAGES.

## Interface
- P_STAGES, 3: maximum modulator order (cascade length), legal range 1..4.
- P_OUT_W, derived (not overridable): P_STAGES+1, the signed output width.
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  a carry sample is presented this cycle.
- i_carry  in  P_STAGES  carry bits; bit k-1 is the carry of stage k (bit 0 = first stage).
- i_cfg_we  in  1  single-cycle pulse that loads i_order.
- i_order  in  3  requested order M, unsigned.
- i_clr  in  1  synchronous clear of all filter state; keeps the current order.
- o_valid  out  1  o_data holds a settled output sample.
- o_data  out  P_OUT_W  signed two's-complement NC output.
- o_order  out  3  active order M.
- o_cfg_err  out  1  sticky flag; set when an illegal i_order is loaded.

## Operation
- Transfer function for active order M:
  - t_M = c_M
  - t_k = c_k·z^-(M-k) + (1−z^-1)·t_(k+1), for k = M−1 down to 1
  - Y = t_1
  - For M=3 this is Y = c1·z^-2 + (1−z^-1)(c2·z^-1 + (1−z^-1)c3).
- Carry bits above M are ignored.
- z^-1 means one accepted sample (i_valid=1), not one clock. With i_valid=0, every delay, differentiator and output register holds.
- Each carry k has a delay line of depth P_STAGES−1. The tap used is M−k.
- Each differentiator register holds the previous t_(k+1).
- Internal sums are P_OUT_W-bit signed.
- Output ranges, with no saturation needed:
  - M=1: 0..1
  - M=2: −1..2
  - M=3: −3..4
  - M=4: −7..8
- Config load: i_cfg_we with 1 ≤ i_order ≤ P_STAGES sets M, clears all delay and differentiator state, and enters FLUSH.
  - An illegal i_order (0 or > P_STAGES) leaves M unchanged, sets o_cfg_err, and changes no state.
  - o_cfg_err clears only on reset.
- State machine:
  - RESET → FLUSH: with M = P_STAGES after reset.
  - FLUSH: counts accepted samples; o_valid=0. After M−1 accepted samples → RUN. For M=1, go directly to RUN.
  - RUN: o_valid follows each accepted sample.
  - A legal config load, or i_clr, in any state → FLUSH with the counter zeroed.
- Simultaneous events:
  - i_cfg_we and i_valid in the same cycle: the sample is discarded, not accepted. The config takes effect.
  - i_clr and i_valid together: the same rule applies.
  - i_clr and i_cfg_we together: apply the config load. It clears the state anyway.

## Timing
- Reset values:
  - o_valid=0
  - o_data=0
  - o_order=P_STAGES
  - o_cfg_err=0
  - all delay and differentiator registers 0
  - state FLUSH, counter 0
- Latency: o_data updates on the clock edge after an accepted sample, i.e. one cycle from i_carry to o_data.
- o_valid is high in the cycle after an accepted sample, and only in RUN. It is low in the cycle after a non-accepted cycle.
- o_data holds its last value while o_valid=0, except that a clear or config load zeroes it on the next edge.
- o_order updates the cycle after a legal i_cfg_we.
- Reset asserted mid-stream forces all reset values immediately (asynchronous). The first sample after release is accepted normally.

## Structure
- Shared package mash_pkg holds:
  - the order type (3-bit)
  - the state enum (FLUSH, RUN)
  - the function that gives the output width from the stage count
  - the P_STAGES legal-range constants
- One sub-module, mash_nc_stage. It holds one carry's delay line with order-selected tap, plus one differentiator register and the adder for t_k. It is instantiated P_STAGES times.
- Tap delays use the existing DELAY_UNIT-style flop chain, extended with a clock enable.

## Test plan
- P_STAGES=3, M=3, after flush:
  - Stimulus: impulse c3=1 for one accepted sample.
  - Required: o_data sequence +1, −2, +1, then 0.
  - Stimulus: impulse on c1.
  - Required: +1 appears on the third accepted output.
- P_STAGES=4, M=4:
  - Carry pattern reaching the extremes. Required: +8 and −7 observed with no wrap.
  - All-ones steady input. Required: settles to constant +1.
- M=3, random carries with i_valid toggling ~50%. Required: o_data matches a golden model clocked on accepted samples only, with o_valid gaps aligned to gaps in i_valid.
- Order switch mid-stream from M=3 to M=1:
  - Required: the sample in the i_cfg_we cycle is dropped, there is no FLUSH gap, and o_data equals c1 from the next accepted sample.
  - Switch to M=2. Required: exactly one hidden sample.
- i_cfg_we with i_order=0, then with i_order=5:
  - Required: o_cfg_err=1, o_order unchanged, the output stream uninterrupted.
- Reset and clear:
  - Async reset asserted mid-RUN. Required: all reset values immediately.
  - i_clr in RUN with M=3. Required: o_valid low for the next 2 accepted samples, and the output restarts from zero state.
